// File: rtl/datapath_prog.sv
// Register-file datapath around a shared W-bit bus and a 4-op ALU.
// Also holds a writable instruction memory, a fetch register and a loadable pc.
module datapath_prog #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int IW   = 8,
  parameter int PCW  = 4,
  parameter int EXTW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREG+2:0] rout,
  input  logic [NREG+1:0] ren,
  input  logic [1:0]      alu_op,
  input  logic            pc_inc,
  input  logic            pc_load,
  input  logic            fetch,
  input  logic            imem_we,
  input  logic [PCW-1:0]  imem_waddr,
  input  logic [IW-1:0]   imem_wdata,
  output logic [IW-1:0]   instruction,
  output logic [PCW-1:0]  pc,
  output logic [W-1:0]    bus,
  output logic            zero,
  output logic            bus_conflict
);

  localparam int DEPTH = 2 ** PCW;

  logic [W-1:0]   regs_r [NREG];
  logic [W-1:0]   a_r;
  logic [W-1:0]   g_r;
  logic           zero_r;
  logic [PCW-1:0] pc_r;
  logic [IW-1:0]  instr_r;
  logic [IW-1:0]  imem_r [DEPTH];

  logic [W-1:0]   bus_s;
  logic [W-1:0]   alu_s;
  logic [W-1:0]   extern_s;

  assign extern_s = W'(instr_r[EXTW-1:0]);

  // Shared bus: OR of every selected source, so overlapping selects stay deterministic.
  always_comb begin
    bus_s = '0;
    for (int k = 0; k < NREG; k++) begin
      bus_s = bus_s | (regs_r[k] & {W{rout[k]}});
    end
    bus_s = bus_s | (g_r      & {W{rout[NREG]}});
    bus_s = bus_s | (a_r      & {W{rout[NREG+1]}});
    bus_s = bus_s | (extern_s & {W{rout[NREG+2]}});
  end

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign bus_conflict = (rout & (rout - (NREG+3)'(1))) != '0;

  // ALU: A op bus, results wrap modulo 2**W.
  always_comb begin
    case (alu_op)
      2'b00:   alu_s = a_r + bus_s;
      2'b01:   alu_s = a_r - bus_s;
      2'b10:   alu_s = a_r ^ bus_s;
      2'b11:   alu_s = a_r & bus_s;
      default: alu_s = '0;
    endcase
  end

  // Register file, A, G and the zero flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs_r[k] <= '0;
      end
      a_r    <= '0;
      g_r    <= '0;
      zero_r <= 1'b1;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (ren[k]) regs_r[k] <= bus_s;
      end
      if (ren[NREG]) begin
        g_r    <= alu_s;
        zero_r <= (alu_s == '0);
      end
      if (ren[NREG+1]) a_r <= bus_s;
    end
  end

  // Program counter (load beats increment) and fetch register reading the pre-edge pc.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r    <= '0;
      instr_r <= '0;
    end else begin
      if (pc_load) pc_r <= bus_s[PCW-1:0];
      else if (pc_inc) pc_r <= pc_r + PCW'(1);
      if (fetch) instr_r <= imem_r[pc_r];
    end
  end

  // Instruction memory: survives reset; a same-cycle fetch sees the old word.
  always_ff @(posedge clock) begin
    if (imem_we) imem_r[imem_waddr] <= imem_wdata;
  end

  assign instruction = instr_r;
  assign pc          = pc_r;
  assign bus         = bus_s;
  assign zero        = zero_r;

endmodule

// File: tb/tb_datapath_prog.sv
// Directed bench for datapath_prog: a behavioural model checked every cycle,
// plus literal expectations taken from hand-worked instruction sequences.
module tb_datapath_prog;

  localparam int GB = 8;   // rout/ren index of G
  localparam int AB = 9;   // rout/ren index of A
  localparam int EB = 10;  // rout index of EXTERN

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] rout = '0;
  logic [9:0]  ren = '0;
  logic [1:0]  alu_op = '0;
  logic        pc_inc = 1'b0, pc_load = 1'b0, fetch = 1'b0, imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [7:0]  imem_wdata = '0;
  logic [7:0]  instruction;
  logic [3:0]  pc;
  logic [15:0] bus;
  logic        zero, bus_conflict;

  int n_vec = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  datapath_prog dut (
    .clock(clock), .reset(reset), .rout(rout), .ren(ren), .alu_op(alu_op),
    .pc_inc(pc_inc), .pc_load(pc_load), .fetch(fetch), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .instruction(instruction),
    .pc(pc), .bus(bus), .zero(zero), .bus_conflict(bus_conflict)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  logic [15:0] m_r [8];
  logic [15:0] m_a, m_g;
  logic        m_zero;
  logic [3:0]  m_pc;
  logic [7:0]  m_instr;
  logic [7:0]  m_imem [16];

  function automatic logic [15:0] m_bus();
    logic [15:0] b = 16'h0000;
    for (int k = 0; k < 8; k++) if (rout[k]) b = b | m_r[k];
    if (rout[GB]) b = b | m_g;
    if (rout[AB]) b = b | m_a;
    if (rout[EB]) b = b | {13'd0, m_instr[2:0]};
    return b;
  endfunction

  function automatic logic [15:0] m_alu(input logic [15:0] b);
    int unsigned r;
    case (alu_op)
      2'd0:    r = (int'(m_a) + int'(b)) % 65536;
      2'd1:    r = (int'(m_a) - int'(b) + 65536) % 65536;
      2'd2:    r = int'(m_a ^ b);
      default: r = int'(m_a & b);
    endcase
    return r[15:0];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) m_r[k] <= 16'h0000;
      m_a <= 16'h0000; m_g <= 16'h0000; m_zero <= 1'b1;
      m_pc <= 4'd0; m_instr <= 8'h00;
    end else begin
      for (int k = 0; k < 8; k++) if (ren[k]) m_r[k] <= m_bus();
      if (ren[GB]) begin
        m_g <= m_alu(m_bus());
        m_zero <= (m_alu(m_bus()) == 16'h0000);
      end
      if (ren[AB]) m_a <= m_bus();
      if (pc_load) m_pc <= m_bus()[3:0];
      else if (pc_inc) m_pc <= 4'((int'(m_pc) + 1) % 16);
      if (fetch) m_instr <= m_imem[m_pc];
      if (imem_we) m_imem[imem_waddr] <= imem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, late in the low phase
  always @(negedge clock) begin
    if (chk_en) begin
      #4;
      chk("m_bus", {16'd0, bus}, {16'd0, m_bus()});
      chk("m_conflict", {31'd0, bus_conflict}, {31'd0, ($countones(rout) > 1)});
      chk("m_pc", {28'd0, pc}, {28'd0, m_pc});
      chk("m_instr", {24'd0, instruction}, {24'd0, m_instr});
      chk("m_zero", {31'd0, zero}, {31'd0, m_zero});
    end
  end

  function automatic logic [10:0] ro1(input int k);
    return 11'd1 << k;
  endfunction

  function automatic logic [9:0] re1(input int k);
    return 10'd1 << k;
  endfunction

  task automatic drive(input logic [10:0] ro, input logic [9:0] re, input logic [1:0] op = 2'd0,
                       input bit inc = 1'b0, input bit ld = 1'b0, input bit fe = 1'b0,
                       input bit we = 1'b0, input logic [3:0] wa = 4'd0, input logic [7:0] wd = 8'h00);
    @(negedge clock);
    #1;
    rout = ro; ren = re; alu_op = op; pc_inc = inc; pc_load = ld; fetch = fe;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
  endtask

  // Builds val in R[dst] by shift-and-add using R6 == 1 and G as the accumulator
  task automatic build(input int dst, input logic [15:0] val);
    drive(11'd0, re1(dst));
    for (int i = 15; i >= 0; i--) begin
      drive(ro1(dst), re1(AB));
      drive(ro1(dst), re1(GB), 2'd0);
      if (val[i]) begin
        drive(ro1(GB), re1(AB));
        drive(ro1(6), re1(GB), 2'd0);
      end
      drive(ro1(GB), re1(dst));
    end
    drive(ro1(dst), 10'd0);
    #2 chk("build", {16'd0, bus}, {16'd0, val});
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    drive(11'd0, 10'd0);
    #2 chk("rst_pc", {28'd0, pc}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);

    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h41);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'h4A);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'h05);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'h07);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 8'h11);

    // Walk the program to R0=5, R1=2, pc=7, G=3
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), re1(6));
    #2 chk("fetch0_instr", {24'd0, instruction}, 32'h41);
    chk("fetch0_pc", {28'd0, pc}, 32'd1);
    chk("fetch0_ext", {16'd0, bus}, 32'd1);
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), re1(1));
    #2 chk("fetch1_instr", {24'd0, instruction}, 32'h4A);
    chk("fetch1_pc", {28'd0, pc}, 32'd2);
    chk("fetch1_ext", {16'd0, bus}, 32'd2);
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), re1(0));
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), 10'd0, 2'd0, 1'b0, 1'b1);
    drive(ro1(0), re1(AB));
    drive(ro1(1), re1(GB), 2'd1);
    drive(ro1(GB), 10'd0);
    #2 chk("pre_rst_g", {16'd0, bus}, 32'd3);
    chk("pre_rst_pc", {28'd0, pc}, 32'd7);
    chk("pre_rst_zero", {31'd0, zero}, 32'd0);

    // Asynchronous reset pulse between edges
    drive(11'd0, 10'd0);
    reset = 1'b1;
    #1 chk("async_pc", {28'd0, pc}, 32'd0);
    chk("async_instr", {24'd0, instruction}, 32'd0);
    chk("async_zero", {31'd0, zero}, 32'd1);
    #1 reset = 1'b0;
    drive(ro1(0) | ro1(GB) | ro1(AB), 10'd0);
    #2 chk("rst_regs", {16'd0, bus}, 32'd0);
    chk("rst_conflict", {31'd0, bus_conflict}, 32'd1);

    // ALU arithmetic: imem[0] survived reset
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), re1(0) | re1(6));
    #2 chk("imem_kept", {24'd0, instruction}, 32'h41);
    drive(11'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(ro1(EB), re1(1));
    drive(ro1(0), re1(AB));
    drive(ro1(1), re1(GB), 2'd0);
    drive(ro1(GB), 10'd0);
    #2 chk("add_g", {16'd0, bus}, 32'd3);
    chk("add_zero", {31'd0, zero}, 32'd0);
    drive(ro1(0), re1(AB));
    drive(ro1(0), re1(GB), 2'd1);
    drive(ro1(GB), 10'd0);
    #2 chk("sub_g", {16'd0, bus}, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);

    build(3, 16'h00FF);
    build(4, 16'h0F0F);
    drive(ro1(3), re1(AB));
    drive(ro1(4), re1(GB), 2'd2);
    drive(ro1(GB), 10'd0);
    #2 chk("xor_g", {16'd0, bus}, 32'h0FF0);
    drive(ro1(4), re1(GB), 2'd3);
    drive(ro1(GB), 10'd0);
    #2 chk("and_g", {16'd0, bus}, 32'h000F);

    // Wraparound of add and pc
    build(3, 16'hFFFF);
    drive(ro1(3), re1(AB));
    drive(ro1(6), re1(GB), 2'd0);
    drive(ro1(GB), 10'd0);
    #2 chk("wrap_g", {16'd0, bus}, 32'd0);
    chk("wrap_zero", {31'd0, zero}, 32'd1);
    build(5, 16'd15);
    drive(ro1(5), 10'd0, 2'd0, 1'b0, 1'b1);
    drive(11'd0, 10'd0, 2'd0, 1'b1);
    #2 chk("pc_15", {28'd0, pc}, 32'd15);
    drive(11'd0, 10'd0);
    #2 chk("pc_wrap", {28'd0, pc}, 32'd0);

    // Bus conflict
    build(0, 16'h00F0);
    build(1, 16'h0F00);
    drive(ro1(0) | ro1(1), 10'd0);
    #2 chk("conf_bus", {16'd0, bus}, 32'h0FF0);
    chk("conf_flag", {31'd0, bus_conflict}, 32'd1);
    drive(11'd0, 10'd0);
    #2 chk("idle_bus", {16'd0, bus}, 32'd0);
    chk("idle_flag", {31'd0, bus_conflict}, 32'd0);

    // Jump beats increment, then read-before-write collision
    build(2, 16'd5);
    drive(ro1(2), 10'd0, 2'd0, 1'b1, 1'b1);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h22);
    #2 chk("jump_pc", {28'd0, pc}, 32'd5);
    drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #2 chk("rbw_old", {24'd0, instruction}, 32'h11);
    drive(11'd0, 10'd0);
    #2 chk("rbw_new", {24'd0, instruction}, 32'h22);

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
